// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: permutation tables, shift amounts,
// mode/state types and the 28-bit half rotations.
package des_pkg;

    typedef enum logic {ENC = 1'b0, DEC = 1'b1} des_mode_t;
    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} des_state_t;

    // Entries are 1-based DES bit numbers of the 64-bit key (bit 1 = MSB).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Entries are 1-based bit numbers of the 56-bit C/D register (bit 1 = MSB).
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // SHIFT_TAB[n-1] is the left-shift amount of DES round n.
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational DES PC-2 permutation: 56-bit C/D value to 48-bit subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    output logic [47:0] o_subkey
);

    genvar gi;
    generate
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            assign o_subkey[47-gi] = i_cd[56-PC2_TAB[gi]];
        end
    endgenerate

    // PC-2 drops C/D bits 9, 18, 22, 25, 35, 38, 43 and 54.
    logic w_unused_bits;
    assign w_unused_bits = ^{i_cd[47], i_cd[38], i_cd[34], i_cd[31],
                             i_cd[21], i_cd[18], i_cd[13], i_cd[2]};

endmodule

// File: rtl/des_key_schedule.sv
// DES round-subkey generator: loads a key through PC-1 and walks the C/D
// register forward (encrypt) or backward (decrypt), one subkey per enable.
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        key_load,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        des_enable,
    output logic [47:0] subkey,
    output logic [3:0]  round,
    output logic        subkey_valid,
    output logic        sched_done
);

    des_state_t r_state, w_state_next;
    des_mode_t  r_mode,  w_mode_next;
    logic [55:0] r_cd,    w_cd_next;
    logic [3:0]  r_round, w_round_next;
    logic        r_done,  w_done_next;

    logic [55:0] w_pc1;
    logic [3:0]  w_shift_idx;
    logic [1:0]  w_shift;

    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            assign w_pc1[55-gi] = key_in[64-PC1_TAB[gi]];
        end
    endgenerate

    // Parity bits 8, 16, ..., 64 never reach the schedule.
    logic w_unused_parity;
    assign w_unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                               key_in[24], key_in[16], key_in[8],  key_in[0]};

    // Encrypt position p moves to C/D of round p+2; decrypt undoes round 16-p.
    assign w_shift_idx = (r_mode == DEC) ? (4'd15 - r_round) : (r_round + 4'd1);
    assign w_shift     = SHIFT_TAB[w_shift_idx];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_mode  <= ENC;
            r_cd    <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mode  <= w_mode_next;
            r_cd    <= w_cd_next;
            r_round <= w_round_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mode_next  = r_mode;
        w_cd_next    = r_cd;
        w_round_next = r_round;
        w_done_next  = 1'b0;
        if (key_load) begin
            w_state_next = S_ACTIVE;
            w_mode_next  = decrypt ? DEC : ENC;
            w_round_next = 4'd0;
            // C16/D16 equal C0/D0, so decrypt starts straight from PC-1.
            w_cd_next    = decrypt ? w_pc1 : rotl_cd(w_pc1, 2'd1);
        end else if (des_enable && (r_state == S_ACTIVE)) begin
            if (r_round == 4'd15) begin
                w_state_next = S_IDLE;
                w_done_next  = 1'b1;
            end else begin
                w_cd_next    = (r_mode == DEC) ? rotr_cd(r_cd, w_shift)
                                               : rotl_cd(r_cd, w_shift);
                w_round_next = r_round + 4'd1;
            end
        end
    end

    des_pc2 u_pc2 (
        .i_cd     (r_cd),
        .o_subkey (subkey)
    );

    assign round        = r_round;
    assign subkey_valid = (r_state == S_ACTIVE);
    assign sched_done   = r_done;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key.
module tb_des_key_schedule;

    logic        clk;
    logic        n_rst;
    logic        key_load;
    logic [63:0] key_in;
    logic        decrypt;
    logic        des_enable;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        subkey_valid;
    logic        sched_done;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] TEST_KEY = 64'h133457799BBCDFF1;

    // Published K1..K16 for the test key.
    localparam logic [47:0] K_TAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_schedule dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .key_load     (key_load),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .des_enable   (des_enable),
        .subkey       (subkey),
        .round        (round),
        .subkey_valid (subkey_valid),
        .sched_done   (sched_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [47:0] exp_key,
                                 input logic [3:0] exp_round, input logic exp_valid,
                                 input logic exp_done);
        check_value($sformatf("%s_subkey", tag), 64'(subkey), 64'(exp_key));
        check_value($sformatf("%s_round", tag), 64'(round), 64'(exp_round));
        check_value($sformatf("%s_valid", tag), 64'(subkey_valid), 64'(exp_valid));
        check_value($sformatf("%s_done", tag), 64'(sched_done), 64'(exp_done));
        $display("t=%0t %s subkey=%h round=%0d valid=%0b done=%0b",
                 $time, tag, subkey, round, subkey_valid, sched_done);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic dec);
        key_load = 1'b1;
        decrypt  = dec;
        tick();
        key_load = 1'b0;
        decrypt  = 1'b0;
    endtask

    // Runs a full schedule, checking every position, the done pulse and post-done enables.
    task automatic run_schedule(input logic dec, input string tag);
        logic [47:0] exp_key;
        load_key(dec);
        for (int p = 0; p < 16; p++) begin
            exp_key = dec ? K_TAB[15-p] : K_TAB[p];
            check_outputs($sformatf("%s_p%0d", tag, p), exp_key, 4'(p), 1'b1, 1'b0);
            des_enable = 1'b1;
            tick();
        end
        des_enable = 1'b0;
        exp_key = dec ? K_TAB[0] : K_TAB[15];
        check_outputs($sformatf("%s_done", tag), exp_key, 4'd15, 1'b0, 1'b1);
        tick();
        check_outputs($sformatf("%s_after", tag), exp_key, 4'd15, 1'b0, 1'b0);
        des_enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_outputs($sformatf("%s_extra%0d", tag, i), exp_key, 4'd15, 1'b0, 1'b0);
        end
        des_enable = 1'b0;
    endtask

    task automatic advance(input int n);
        des_enable = 1'b1;
        for (int i = 0; i < n; i++) tick();
        des_enable = 1'b0;
    endtask

    initial begin
        n_rst      = 1'b0;
        key_load   = 1'b0;
        key_in     = TEST_KEY;
        decrypt    = 1'b0;
        des_enable = 1'b0;
        tick();
        check_outputs("reset", 48'h0, 4'd0, 1'b0, 1'b0);
        tick();
        n_rst = 1'b1;
        tick();
        check_outputs("post_reset", 48'h0, 4'd0, 1'b0, 1'b0);

        des_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outputs($sformatf("idle_en%0d", i), 48'h0, 4'd0, 1'b0, 1'b0);
        end
        des_enable = 1'b0;

        run_schedule(1'b0, "enc");
        run_schedule(1'b1, "dec");

        // Restart mid-schedule, then load and enable together.
        load_key(1'b0);
        advance(7);
        check_outputs("pre_restart", K_TAB[7], 4'd7, 1'b1, 1'b0);
        load_key(1'b0);
        check_outputs("restart", K_TAB[0], 4'd0, 1'b1, 1'b0);
        advance(3);
        check_outputs("pre_simul", K_TAB[3], 4'd3, 1'b1, 1'b0);
        des_enable = 1'b1;
        load_key(1'b1);
        des_enable = 1'b0;
        check_outputs("simul", K_TAB[15], 4'd0, 1'b1, 1'b0);

        // Load + enable on the last position aborts without a done pulse.
        advance(15);
        check_outputs("pre_abort15", K_TAB[0], 4'd15, 1'b1, 1'b0);
        des_enable = 1'b1;
        load_key(1'b0);
        des_enable = 1'b0;
        check_outputs("abort15", K_TAB[0], 4'd0, 1'b1, 1'b0);
        tick();
        check_outputs("abort15_next", K_TAB[0], 4'd0, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        advance(5);
        check_outputs("pre_areset", K_TAB[5], 4'd5, 1'b1, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        check_outputs("areset", 48'h0, 4'd0, 1'b0, 1'b0);
        tick();
        n_rst = 1'b1;
        des_enable = 1'b1;
        tick();
        des_enable = 1'b0;
        check_outputs("areset_idle", 48'h0, 4'd0, 1'b0, 1'b0);
        load_key(1'b0);
        check_outputs("reload", K_TAB[0], 4'd0, 1'b1, 1'b0);
        advance(1);
        check_outputs("reload_k2", K_TAB[1], 4'd1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Generates the sixteen 48-bit DES round subkeys, one per round, for the round computation datapath. It works in encrypt order (K1..K16) or decrypt order (K16..K1). The block loads a 64-bit key, applies PC-1, then rotates the 56-bit C/D register each round. It presents PC-2 of the current C/D value on `subkey` combinationally, so the round datapath consumes the value in the same cycle it advances. It sits between the DES controller and the round computation block, on the producing end of the subkey interface.

## Interface
- No parameters; all widths are fixed by the DES standard.
- `clk` – input – 1 – system clock, rising edge.
- `n_rst` – input – 1 – asynchronous, active-low reset.
- `key_load` – input – 1 – single-cycle pulse; captures `key_in` and `decrypt` and starts a new schedule.
- `key_in` – input – 64 – DES key, bit 63 = DES bit 1; parity bits ignored via PC-1.
- `decrypt` – input – 1 – 0 selects K1..K16, 1 selects K16..K1; sampled only with `key_load`.
- `des_enable` – input – 1 – same strobe the round block uses; advances to the next subkey.
- `subkey` – output – 48 – PC-2 of the current C/D register; bit 47 = PC-2 output bit 1.
- `round` – output – 4 – position in the sequence, 0..15.
- `subkey_valid` – output – 1 – high while `subkey` is a live schedule entry.
- `sched_done` – output – 1 – single-cycle pulse the cycle after the 16th subkey is consumed.

## Operation
- Registers:
  - `cd[55:0]`, holding C in `cd[55:28]` and D in `cd[27:0]`.
  - `round[3:0]`.
  - latched `mode`.
  - state ∈ {IDLE, ACTIVE}.
  - `done` flag.
- Shift table: `shift(n) = 1` for DES rounds n ∈ {1, 2, 9, 16}; `shift(n) = 2` otherwise.
- `key_load` (any state):
  - `mode <= decrypt`; `round <= 0`; state goes to ACTIVE.
  - Encrypt: `cd <= rotl(PC1(key_in), 1)`, so position 0 is K1.
  - Decrypt: `cd <= PC1(key_in)`, so position 0 is K16 (C16 = C0).
  - Rotations act on each 28-bit half independently.
- `des_enable` in ACTIVE with `round < 15`:
  - Encrypt: `cd <= rotl(cd, shift(round+2))`.
  - Decrypt: `cd <= rotr(cd, shift(16-round))`.
  - `round <= round + 1`.
- `des_enable` in ACTIVE with `round == 15`:
  - state goes to IDLE; `round` holds 15; `cd` is not rotated; `done` pulses for one cycle.
- `des_enable` in IDLE is ignored: no change, no done pulse.
- `key_load` and `des_enable` in the same cycle: load wins and the enable is dropped.
- `key_load` mid-schedule aborts the current schedule without a done pulse and restarts at position 0.
- `subkey = PC2(cd)` is continuous in every state. After completion it holds the last subkey (K16 for encrypt, K1 for decrypt).
- `subkey_valid = (state == ACTIVE)`.

## Timing
- Reset values:
  - `cd = 0`, `round = 0`, state IDLE, `mode = 0`, `done = 0`.
  - Outputs: `subkey = 0`, `subkey_valid = 0`, `sched_done = 0`.
- Load latency: the first subkey is valid on `subkey` the cycle after `key_load`.
- Advance: combinational `subkey` is valid for the whole cycle in which `des_enable` is high. The next subkey appears after that rising edge, which matches the round block registering on the same edge.
- Throughput: one subkey per cycle, with no bubbles.
- The 16th `des_enable` edge clears `subkey_valid` and raises `sched_done` for exactly one cycle.
- Asserting `n_rst` asynchronously returns the block to its reset values immediately, including mid-schedule; the next action requires a new `key_load`.

## Structure
- Shared package `des_pkg` holds:
  - the PC-1 and PC-2 index constants and the shift-amount constant array;
  - the `des_mode_t` typedef (ENC/DEC) and the state enum.
- One natural sub-module, `des_pc2`: the purely combinational 56→48 permutation, reusable by any future pipelined key schedule.
- PC-1 and the rotations stay inline.

## Test plan
- Encrypt order:
  - Stimulus: `key_in = 64'h133457799BBCDFF1`, `decrypt = 0`, load.
  - Required: `subkey = 48'h1B02EFFC7072` with `subkey_valid = 1` and `round = 0`.
  - After 15 enables: `subkey = 48'hCB3D8B0E17F5` with `round = 15`.
- Decrypt order:
  - Stimulus: same key, `decrypt = 1`, load.
  - Required: position 0 = `48'hCB3D8B0E17F5`; position 15 = `48'h1B02EFFC7072`.
  - All 16 subkeys equal the encrypt sequence reversed.
- Completion:
  - Stimulus: 16 consecutive enables.
  - Required: `sched_done` high exactly one cycle after the 16th; `subkey_valid` goes to 0; extra enables change nothing.
- Restart and simultaneous events:
  - Stimulus: `key_load` at `round = 7`, then a cycle with `key_load` and `des_enable` both high.
  - Required: each load restarts at `round = 0` with position-0 subkey; no done pulse.
- Idle enable:
  - Stimulus: enables after reset with no load.
  - Required: `subkey = 0`, `round = 0`, `subkey_valid = 0`, no `sched_done`.
- Reset mid-schedule:
  - Stimulus: drop `n_rst` asynchronously between edges at `round = 5`.
  - Required: all outputs go to zero immediately; a subsequent load yields K1 again.
